// File: rtl/fib_pkg.sv
// Shared types and default widths for the fibonacci sweep controller.
// Both the controller and its result FIFO import this package.
package fib_pkg;

  localparam int N_WIDTH_DEF     = 32;
  localparam int DATA_WIDTH_DEF  = 32;
  localparam int FIFO_DEPTH_DEF  = 8;
  localparam int ACK_TIMEOUT_DEF = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_ACK,
    ST_RUN,
    ST_PUSH,
    ST_FIN
  } sweep_state_e;

  typedef struct packed {
    logic [N_WIDTH_DEF-1:0]    n;
    logic [DATA_WIDTH_DEF-1:0] data;
  } fib_entry_t;

endpackage

// File: rtl/fib_res_fifo.sv
// First-word fall-through sync FIFO of result entries. The head is held in a
// register that is refilled from the array one cycle ahead, with a write bypass.
module fib_res_fifo
  import fib_pkg::*;
#(
  parameter type entry_t = fib_entry_t,
  parameter int  DEPTH   = FIFO_DEPTH_DEF
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  entry_t                 push_data_i,
  input  logic                   pop_i,
  output entry_t                 head_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);

  entry_t          mem [DEPTH];
  entry_t          head_reg;
  logic [AW-1:0]   wr_ptr_reg;
  logic [AW-1:0]   rd_ptr_reg;
  logic [AW-1:0]   rd_ptr_next;
  logic [AW:0]     count_reg;
  logic [AW:0]     count_next;
  logic            do_push;
  logic            do_pop;

  assign empty_o = (count_reg == '0);
  assign full_o  = (count_reg == (AW+1)'(DEPTH));
  assign count_o = count_reg;
  assign head_o  = head_reg;

  // A push into a full FIFO is accepted only when a pop frees a slot that cycle.
  always_comb begin
    do_pop      = pop_i && !empty_o;
    do_push     = push_i && (!full_o || do_pop);
    rd_ptr_next = rd_ptr_reg + AW'(do_pop);
    count_next  = count_reg;
    if (do_push && !do_pop) begin
      count_next = count_reg + 1'b1;
    end else if (!do_push && do_pop) begin
      count_next = count_reg - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data_i;
    end
  end

  // Prefetch the entry that will be at the head next cycle; bypass when it is
  // the one being written right now.
  always_ff @(posedge clk_i) begin
    if (do_push && (wr_ptr_reg == rd_ptr_next)) begin
      head_reg <= push_data_i;
    end else begin
      head_reg <= mem[rd_ptr_next];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

endmodule

// File: rtl/fib_sweep_ctrl.sv
// Sweeps n over [first_i, last_i], starts the fibonacci core once per n, and
// queues each (n, result) pair into a FWFT FIFO drained by a valid/ready stream.
module fib_sweep_ctrl
  import fib_pkg::*;
#(
  parameter int N_WIDTH     = N_WIDTH_DEF,
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int FIFO_DEPTH  = FIFO_DEPTH_DEF,
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  go_i,
  input  logic [N_WIDTH-1:0]    first_i,
  input  logic [N_WIDTH-1:0]    last_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  core_start_o,
  output logic [N_WIDTH-1:0]    core_n_o,
  input  logic [DATA_WIDTH-1:0] core_result_i,
  input  logic                  core_busy_i,
  output logic                  res_valid_o,
  input  logic                  res_ready_i,
  output logic [N_WIDTH-1:0]    res_n_o,
  output logic [DATA_WIDTH-1:0] res_data_o
);

  localparam int CW  = $clog2(FIFO_DEPTH) + 1;
  localparam int AKW = $clog2(ACK_TIMEOUT + 1);

  typedef struct packed {
    logic [N_WIDTH-1:0]    n;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  sweep_state_e       state_reg, state_next;
  logic [N_WIDTH-1:0] cur_reg, cur_next;
  logic [N_WIDTH-1:0] last_reg, last_next;
  logic [N_WIDTH-1:0] core_n_reg, core_n_next;
  logic [AKW-1:0]     ack_cnt_reg, ack_cnt_next;
  logic               start_reg, start_next;
  logic               done_pulse;

  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CW-1:0]      fifo_count;
  entry_t             push_entry;
  entry_t             head_entry;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg   <= ST_IDLE;
      cur_reg     <= '0;
      last_reg    <= '0;
      core_n_reg  <= '0;
      ack_cnt_reg <= '0;
      start_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cur_reg     <= cur_next;
      last_reg    <= last_next;
      core_n_reg  <= core_n_next;
      ack_cnt_reg <= ack_cnt_next;
      start_reg   <= start_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cur_next     = cur_reg;
    last_next    = last_reg;
    core_n_next  = core_n_reg;
    ack_cnt_next = ack_cnt_reg;
    start_next   = 1'b0;
    fifo_push    = 1'b0;
    done_pulse   = 1'b0;

    unique case (state_reg)
      ST_IDLE: begin
        if (go_i) begin
          cur_next   = first_i;
          last_next  = last_i;
          state_next = (first_i > last_i) ? ST_FIN : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // Reserving a FIFO slot here is what lets PUSH write unconditionally.
        if (!fifo_full && !core_busy_i) begin
          start_next   = 1'b1;
          core_n_next  = cur_reg;
          ack_cnt_next = '0;
          state_next   = ST_ACK;
        end
      end
      ST_ACK: begin
        if (core_busy_i) begin
          state_next = ST_RUN;
        end else if (ack_cnt_reg == AKW'(ACK_TIMEOUT - 1)) begin
          state_next = ST_PUSH;
        end else begin
          ack_cnt_next = ack_cnt_reg + AKW'(1);
        end
      end
      ST_RUN: begin
        if (!core_busy_i) begin
          state_next = ST_PUSH;
        end
      end
      ST_PUSH: begin
        fifo_push = 1'b1;
        // Compare before incrementing so a range ending at all-ones never wraps.
        if (cur_reg == last_reg) begin
          state_next = ST_FIN;
        end else begin
          cur_next   = cur_reg + N_WIDTH'(1);
          state_next = ST_ISSUE;
        end
      end
      ST_FIN: begin
        if (fifo_count == '0) begin
          done_pulse = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    push_entry      = '0;
    push_entry.n    = cur_reg;
    push_entry.data = core_result_i;
  end

  assign fifo_pop = res_valid_o && res_ready_i;

  fib_res_fifo #(
    .entry_t (entry_t),
    .DEPTH   (FIFO_DEPTH)
  ) u_res_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (fifo_push),
    .push_data_i (push_entry),
    .pop_i       (fifo_pop),
    .head_o      (head_entry),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  assign busy_o       = (state_reg != ST_IDLE);
  assign done_o       = done_pulse;
  assign core_start_o = start_reg;
  assign core_n_o     = core_n_reg;
  assign res_valid_o  = !fifo_empty;
  assign res_n_o      = head_entry.n;
  assign res_data_o   = head_entry.data;

endmodule

// File: tb/tb_fib_sweep_ctrl.sv
// Randomised and directed checks of fib_sweep_ctrl against an expected-result
// queue built from plain fibonacci arithmetic, with a behavioural core model.
module tb_fib_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        go = 1'b0;
  logic [31:0] f_in = '0;
  logic [31:0] l_in = '0;
  logic        busy_o, done_o, core_start_o, res_valid_o;
  logic [31:0] core_n_o, res_n_o, res_data_o;
  logic [31:0] core_result;
  logic        core_busy;
  logic        res_ready = 1'b0;

  always #5 clk = ~clk;

  fib_sweep_ctrl dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .go_i          (go),
    .first_i       (f_in),
    .last_i        (l_in),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .core_start_o  (core_start_o),
    .core_n_o      (core_n_o),
    .core_result_i (core_result),
    .core_busy_i   (core_busy),
    .res_valid_o   (res_valid_o),
    .res_ready_i   (res_ready),
    .res_n_o       (res_n_o),
    .res_data_o    (res_data_o)
  );

  typedef struct packed {
    logic [31:0] n;
    logic [31:0] d;
  } exp_t;

  exp_t        expq[$];
  exp_t        cmp_e;
  int          total = 0;
  int          bad = 0;
  int          starts = 0;
  int          pops = 0;
  int          dones = 0;
  int          cyc = 0;
  int          last_start_cyc = 0;
  bit          gap_chk = 0;
  bit          gap_prev = 0;
  logic [31:0] last_pop_n = '0;
  logic [31:0] last_pop_d = '0;
  int          ready_mode = 1;
  int          core_mode = 0;

  function automatic logic [31:0] fib(input int n);
    logic [31:0] a, b, t;
    a = 0;
    b = 1;
    for (int i = 0; i < n; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Behavioural core: busy for n+1 cycles after a start, then holds fib(n).
  initial begin
    int          cnt;
    logic [31:0] n_lat;
    cnt = 0;
    n_lat = 0;
    core_busy = 1'b0;
    core_result = '0;
    forever begin
      @(posedge clk);
      if (core_mode == 1) begin
        core_busy   <= 1'b0;
        core_result <= 32'hDEAD;
      end else if (!core_busy && core_start_o) begin
        core_busy   <= 1'b1;
        n_lat = core_n_o;
        cnt = int'(core_n_o) + 1;
        core_result <= 32'hBAD0BAD0;
      end else if (core_busy) begin
        cnt = cnt - 1;
        if (cnt <= 0) begin
          core_busy   <= 1'b0;
          core_result <= fib(int'(n_lat));
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: res_ready = 1'b0;
        1: res_ready = 1'b1;
        default: res_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Compare process: every pop against the expected queue, every start against FIFO room.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        starts = 0;
        pops = 0;
      end else begin
        if (res_valid_o && res_ready) begin
          chk("pop_q_nonempty", 64'(expq.size() > 0), 1);
          if (expq.size() > 0) begin
            cmp_e = expq.pop_front();
            chk("res_n", res_n_o, cmp_e.n);
            chk("res_data", res_data_o, cmp_e.d);
          end
          last_pop_n = res_n_o;
          last_pop_d = res_data_o;
          pops++;
        end
        if (core_start_o) begin
          chk("start_room", 64'((starts - pops) < 8), 1);
          if (gap_chk && gap_prev) chk("ack_gap", cyc - last_start_cyc, 6);
          gap_prev = 1;
          last_start_cyc = cyc;
          starts++;
        end
        if (done_o) begin
          dones++;
          chk("done_drained", expq.size(), 0);
        end
      end
    end
  end

  task automatic do_go(input logic [31:0] f, input logic [31:0] l);
    @(posedge clk);
    #1;
    go = 1'b1;
    f_in = f;
    l_in = l;
    @(posedge clk);
    #1;
    go = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok, output int ncyc);
    ok = 0;
    ncyc = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done_o) begin
        ok = 1;
        ncyc = i + 1;
        break;
      end
    end
  endtask

  task automatic load_exp(input logic [31:0] f, input logic [31:0] l, output int nexp);
    nexp = 0;
    for (longint k = longint'(f); k <= longint'(l); k++) begin
      exp_t e;
      e.n = k[31:0];
      if (core_mode == 1) e.d = 32'hDEAD;
      else e.d = fib(int'(k));
      expq.push_back(e);
      nexp++;
    end
  endtask

  task automatic run_sweep(input logic [31:0] f, input logic [31:0] l);
    int s0, d0, nexp, ncyc;
    bit ok;
    s0 = starts;
    d0 = dones;
    load_exp(f, l, nexp);
    do_go(f, l);
    wait_done(20000, ok, ncyc);
    chk("done_seen", 64'(ok), 1);
    repeat (3) @(negedge clk);
    chk("starts", starts - s0, nexp);
    chk("done_once", dones - d0, 1);
    chk("busy_after", busy_o, 0);
    chk("q_drained", expq.size(), 0);
    $display("sweep first=%0h last=%0h entries=%0d cycles=%0d", f, l, nexp, ncyc);
  endtask

  initial begin
    int  s0, d0, nexp, ncyc;
    bit  ok;
    logic [31:0] f, l;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_start", core_start_o, 0);
    chk("rst_core_n", core_n_o, 0);
    chk("rst_valid", res_valid_o, 0);
    rst = 1'b0;

    // Plain sweep 0..9 with an always-ready consumer.
    ready_mode = 1;
    core_mode = 0;
    run_sweep(0, 9);
    chk("t1_last_n", last_pop_n, 9);
    chk("t1_last_d", last_pop_d, 34);

    run_sweep(5, 5);
    chk("t2_n", last_pop_n, 5);
    chk("t2_d", last_pop_d, 5);

    // Empty range: no starts, quick done.
    s0 = starts;
    d0 = dones;
    do_go(7, 3);
    wait_done(50, ok, ncyc);
    chk("empty_done_seen", 64'(ok), 1);
    chk("empty_done_lat", 64'(ncyc <= 3), 1);
    repeat (3) @(negedge clk);
    chk("empty_starts", starts - s0, 0);
    chk("empty_done_once", dones - d0, 1);
    chk("empty_valid", res_valid_o, 0);
    $display("sweep first=7 last=3 entries=0 cycles=%0d", ncyc);

    // Backpressure: consumer stalled until the FIFO fills.
    ready_mode = 0;
    s0 = starts;
    d0 = dones;
    load_exp(0, 19, nexp);
    do_go(0, 19);
    ok = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (starts - s0 >= 8) begin
        ok = 1;
        break;
      end
    end
    chk("bp_reach8", 64'(ok), 1);
    repeat (100) @(negedge clk);
    chk("bp_starts", starts - s0, 8);
    chk("bp_valid", res_valid_o, 1);
    chk("bp_head_n", res_n_o, 0);
    chk("bp_busy", busy_o, 1);
    ready_mode = 1;
    wait_done(20000, ok, ncyc);
    chk("bp_done_seen", 64'(ok), 1);
    repeat (3) @(negedge clk);
    chk("bp_starts_all", starts - s0, 20);
    chk("bp_done_once", dones - d0, 1);
    chk("bp_last_n", last_pop_n, 19);
    chk("bp_last_d", last_pop_d, 4181);
    $display("sweep first=0 last=19 backpressure cycles=%0d", ncyc);

    // Core that never acknowledges: each n taken after the ack timeout.
    core_mode = 1;
    repeat (2) @(posedge clk);
    gap_chk = 1;
    gap_prev = 0;
    run_sweep(3, 6);
    gap_chk = 0;
    chk("to_last_d", last_pop_d, 32'hDEAD);
    run_sweep(32'hFFFF_FFFE, 32'hFFFF_FFFF);
    chk("wrap_last_n", last_pop_n, 32'hFFFF_FFFF);
    core_mode = 0;
    repeat (2) @(posedge clk);

    // Reset in the middle of a sweep.
    d0 = dones;
    load_exp(0, 9, nexp);
    do_go(0, 9);
    ok = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (core_start_o && core_n_o == 4) begin
        ok = 1;
        break;
      end
    end
    chk("mid_n4_seen", 64'(ok), 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_busy", busy_o, 0);
    chk("mid_done", done_o, 0);
    chk("mid_start", core_start_o, 0);
    chk("mid_core_n", core_n_o, 0);
    chk("mid_valid", res_valid_o, 0);
    rst = 1'b0;
    expq.delete();
    repeat (20) @(negedge clk);
    chk("mid_no_done", dones - d0, 0);
    chk("mid_idle", busy_o, 0);
    $display("reset mid-sweep at n=4");
    run_sweep(1, 2);
    chk("post_rst_n", last_pop_n, 2);
    chk("post_rst_d", last_pop_d, 1);

    // Randomised ranges, consumer readiness and core behaviour.
    ready_mode = 2;
    for (int r = 0; r < 8; r++) begin
      core_mode = (r % 3 == 2) ? 1 : 0;
      repeat (2) @(posedge clk);
      f = 32'($urandom_range(0, 15));
      l = f + 32'($urandom_range(0, 6));
      run_sweep(f, l);
    end
    ready_mode = 1;
    core_mode = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
